sd1011_pattern_tx: RTL and testbench

Serial pattern transmitter that generates the framed bitstream the 1011 sequence detector consumes.
- Sends a fixed PAT_W-bit pattern (default 1011), MSB first, one bit per clock.
- Repeats the pattern a programmable number of times, with an optional run of idle zeros between repeats.
- Sits upstream of the detector as its stimulus/data source; dout connects directly to the detector's din.

---
 rtl/sd_pkg.sv | 19 +
 rtl/sd1011_pattern_tx_if.sv | 35 +++
 rtl/sd_piso_shreg.sv | 36 +++
 rtl/sd1011_pattern_tx.sv | 149 ++++++++++++++
 tb/tb_sd1011_pattern_tx.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// ----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the 1011 pattern transmitter and detector.
//   state_t      : one-hot transmitter states (IDLE, SEND, GAP, DONE)
//   PATTERN_1011 : default serial pattern, sent MSB first
// ----------------------------------------------------------------------------
package sd_pkg;

  // One-hot encoding keeps every output decode down to a single state bit.
  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    SEND = 4'b0010,
    GAP  = 4'b0100,
    DONE = 4'b1000
  } state_t;

  localparam logic [3:0] PATTERN_1011 = 4'b1011;

endpackage

// File: rtl/sd1011_pattern_tx_if.sv
// ----------------------------------------------------------------------------
// sd1011_pattern_tx_if
// Control and serial-data bundle of the pattern transmitter.
//   start, repeat_n, gap, abort      : requests from the controlling side
//   dout, dout_valid, frame_start,
//   busy, done                       : serial stream and status back
// modport master : the side issuing requests (bench / controller)
// modport slave  : the transmitter itself
// ----------------------------------------------------------------------------
interface sd1011_pattern_tx_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);

  logic             start;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             dout;
  logic             dout_valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
    output start, repeat_n, gap, abort,
    input  dout, dout_valid, frame_start, busy, done
  );

  modport slave (
    input  start, repeat_n, gap, abort,
    output dout, dout_valid, frame_start, busy, done
  );

endinterface

// File: rtl/sd_piso_shreg.sv
// ----------------------------------------------------------------------------
// sd_piso_shreg
// W-bit parallel-load / serial-out shift register, MSB first.
//   clk, reset : clock and asynchronous active-high reset
//   load       : capture pin (takes priority over shift)
//   shift      : move one bit towards the MSB, filling with 0
//   pin        : parallel load value
//   sout       : current MSB, straight from a flop
// ----------------------------------------------------------------------------
module sd_piso_shreg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] pin,
  output logic         sout
);

  logic [W-1:0] shreg_q;

  // Load wins over shift so a back-to-back reload never loses the new MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
    end else if (load) begin
      shreg_q <= pin;
    end else if (shift) begin
      shreg_q <= {shreg_q[W-2:0], 1'b0};
    end
  end

  assign sout = shreg_q[W-1];

endmodule

// File: rtl/sd1011_pattern_tx.sv
// ----------------------------------------------------------------------------
// sd1011_pattern_tx
// Serial pattern transmitter feeding the 1011 sequence detector. Sends
// PATTERN MSB first, repeat_n times (0 counts as 1), with gap idle-zero
// cycles between consecutive patterns.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slave side of sd1011_pattern_tx_if
//                start/repeat_n/gap/abort in, dout/dout_valid/
//                frame_start/busy/done out
// ----------------------------------------------------------------------------
module sd1011_pattern_tx
  import sd_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PATTERN_1011),
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sd1011_pattern_tx_if.slave   bus
);

  localparam int               IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic               sh_load;
  logic               sh_shift;
  logic [PAT_W-1:0]   sh_pin;
  logic               sh_out;

  // The shifter holds zeros outside SEND, so its MSB is directly dout.
  sd_piso_shreg #(.W(PAT_W)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .pin   (sh_pin),
    .sout  (sh_out)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters: remaining patterns, latched gap length, gap and bit position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      bit_idx_q <= '0;
    end else begin
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Next-state and shifter control. Every exit from SEND/GAP that is not a
  // reload clears the shifter so dout drops to 0 on the following cycle.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    bit_idx_d = bit_idx_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_pin    = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          rem_d     = (bus.repeat_n == '0) ? CNT_W'(1) : bus.repeat_n;
          gap_d     = bus.gap;
          sh_load   = 1'b1;
          sh_pin    = PATTERN;
          bit_idx_d = IDX_MSB;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (bus.abort) begin
          sh_load   = 1'b1;
          rem_d     = '0;
          bit_idx_d = '0;
          state_d   = IDLE;
        end else if (bit_idx_q == '0) begin
          // LSB just went out: count this pattern, saturating at zero.
          rem_d = (rem_q == '0) ? '0 : rem_q - CNT_W'(1);
          if (rem_q <= CNT_W'(1)) begin
            sh_load = 1'b1;
            state_d = DONE;
          end else if (gap_q == '0) begin
            sh_load   = 1'b1;
            sh_pin    = PATTERN;
            bit_idx_d = IDX_MSB;
          end else begin
            sh_load   = 1'b1;
            gap_cnt_d = gap_q;
            state_d   = GAP;
          end
        end else begin
          sh_shift  = 1'b1;
          bit_idx_d = bit_idx_q - IDX_W'(1);
        end
      end
      GAP: begin
        if (bus.abort) begin
          rem_d     = '0;
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          gap_cnt_d = '0;
          sh_load   = 1'b1;
          sh_pin    = PATTERN;
          bit_idx_d = IDX_MSB;
          state_d   = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.dout        = sh_out;
  assign bus.dout_valid  = (state_q == SEND);
  assign bus.frame_start = (state_q == SEND) && (bit_idx_q == IDX_MSB);
  assign bus.busy        = (state_q == SEND) || (state_q == GAP);
  assign bus.done        = (state_q == DONE);

endmodule

// File: tb/tb_sd1011_pattern_tx.sv
// ----------------------------------------------------------------------------
// tb_sd1011_pattern_tx
// Directed bench for sd1011_pattern_tx. Each step drives the request inputs
// and compares {dout, dout_valid, frame_start, busy, done} cycle by cycle
// against hand-written bit strings.
// ----------------------------------------------------------------------------
module tb_sd1011_pattern_tx;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  sd1011_pattern_tx_if #(.CNT_W(8), .GAP_W(4)) bus ();

  sd1011_pattern_tx #(
    .PAT_W   (4),
    .PATTERN (4'b1011),
    .CNT_W   (8),
    .GAP_W   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the request inputs; sampled at the next rising edge.
  task automatic applyStimulus(input logic s, input logic [7:0] n,
                               input logic [3:0] g, input logic a);
    bus.start    = s;
    bus.repeat_n = n;
    bus.gap      = g;
    bus.abort    = a;
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Compare the packed output vector against an expected value.
  task automatic checkOutput(input string tag, input int idx, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {bus.dout, bus.dout_valid, bus.frame_start, bus.busy, bus.done};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s cyc %0d: got {dout,vld,fs,busy,done}=%b want %b",
             tag, idx, obs, exp);
    end
  endtask

  // Check n consecutive cycles; bit n-1 of each string is the first cycle.
  task automatic expectRun(input string tag, input int n,
                           input logic [31:0] d, input logic [31:0] v,
                           input logic [31:0] f, input logic [31:0] b,
                           input logic [31:0] dn);
    for (int i = 0; i < n; i++) begin
      checkOutput(tag, i, {d[n-1-i], v[n-1-i], f[n-1-i], b[n-1-i], dn[n-1-i]});
      stepCycle();
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    applyStimulus(1'b0, 8'd0, 4'd0, 1'b0);

    // Reset state, while held and after release.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_held", 0, 5'b00000);
    reset = 1'b0;
    expectRun("reset_idle", 2, 0, 0, 0, 0, 0);

    // Reset mid-transfer: 3 back-to-back patterns, reset in the 2nd.
    applyStimulus(1'b1, 8'd3, 4'd0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 8'd3, 4'd0, 1'b0);
    expectRun("rstmid_pre", 6, 6'b1011_10, 6'b111111, 6'b1000_10, 6'b111111, 0);
    reset = 1'b1;
    #2;
    checkOutput("rstmid_async", 0, 5'b00000);
    stepCycle();
    reset = 1'b0;
    expectRun("rstmid_after", 4, 0, 0, 0, 0, 0);

    // Single pattern.
    applyStimulus(1'b1, 8'd1, 4'd0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 8'd1, 4'd0, 1'b0);
    expectRun("single", 6, 6'b101100, 6'b111100, 6'b100000, 6'b111100, 6'b000010);

    // Back-to-back repeats.
    applyStimulus(1'b1, 8'd2, 4'd0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 8'd2, 4'd0, 1'b0);
    expectRun("b2b", 10, 10'b1011_1011_0_0, 10'b1111_1111_0_0, 10'b1000_1000_0_0,
              10'b1111_1111_0_0, 10'b0000_0000_1_0);

    // Gap insertion.
    applyStimulus(1'b1, 8'd3, 4'd2, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 8'd3, 4'd2, 1'b0);
    expectRun("gap", 18,
              18'b1011_00_1011_00_1011_0_0, 18'b1111_00_1111_00_1111_0_0,
              18'b1000_00_1000_00_1000_0_0, 18'b1111_11_1111_11_1111_0_0,
              18'b0000_00_0000_00_0000_1_0);

    // repeat_n=0 acts as 1; start while busy and in DONE is ignored.
    applyStimulus(1'b1, 8'd0, 4'd0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 8'd0, 4'd0, 1'b0);
    expectRun("rep0_a", 2, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00);
    applyStimulus(1'b1, 8'd5, 4'd3, 1'b0);
    expectRun("rep0_busystart", 1, 1, 1, 0, 1, 0);
    applyStimulus(1'b0, 8'd5, 4'd3, 1'b0);
    expectRun("rep0_lsb", 1, 1, 1, 0, 1, 0);
    applyStimulus(1'b1, 8'd5, 4'd3, 1'b0);
    expectRun("rep0_done", 1, 0, 0, 0, 0, 1);
    applyStimulus(1'b0, 8'd0, 4'd0, 1'b0);
    expectRun("rep0_idle", 3, 0, 0, 0, 0, 0);

    // Abort on the 3rd bit of pattern 2 (repeat_n=5, gap=1).
    applyStimulus(1'b1, 8'd5, 4'd1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 8'd5, 4'd1, 1'b0);
    expectRun("abort_pre", 7, 7'b1011_0_10, 7'b1111_0_11, 7'b1000_0_10,
              7'b1111111, 0);
    applyStimulus(1'b0, 8'd5, 4'd1, 1'b1);
    expectRun("abort_bit3", 1, 1, 1, 0, 1, 0);
    applyStimulus(1'b0, 8'd5, 4'd1, 1'b0);
    expectRun("abort_after", 5, 0, 0, 0, 0, 0);

    // Start together with abort in IDLE: start wins, normal single run.
    applyStimulus(1'b1, 8'd1, 4'd0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 8'd1, 4'd0, 1'b0);
    expectRun("restart", 6, 6'b101100, 6'b111100, 6'b100000, 6'b111100, 6'b000010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
